// File: rtl/aes_gcm_tag_verify.sv
// Receive-side GCM tag check: GHASH over AAD+ciphertext blocks, then the length block,
// XOR with E(K,J0) and compare against the received tag. One GF(2^128) multiply per cycle.
module aes_gcm_tag_verify #(
    parameter int unsigned TAG_BITS = 128  // legal range 96..128
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [127:0] i_instance_size,
    input  logic [127:0] i_h,
    input  logic [127:0] i_encrypted_j0,
    input  logic [127:0] i_expected_tag,
    input  logic         i_valid,
    input  logic [127:0] i_block,
    output logic         o_ready,
    output logic         o_busy,
    output logic         o_done,
    output logic [127:0] o_tag,
    output logic         o_tag_ok
);

    typedef enum logic [1:0] {
        StIdle,
        StAbsorb,
        StLen
    } state_e;

    // GCM bit-reflected product: vector bit 127 is polynomial coefficient x^0.
    function automatic logic [127:0] fn_product(input logic [127:0] x, input logic [127:0] y);
        logic [127:0] z;
        logic [127:0] v;
        logic [127:0] xs;
        z  = '0;
        v  = y;
        xs = x;
        for (int i = 0; i < 128; i++) begin
            if (xs[127]) begin
                z = z ^ v;
            end
            if (v[0]) begin
                v = (v >> 1) ^ {8'he1, 120'd0};
            end else begin
                v = v >> 1;
            end
            xs = xs << 1;
        end
        return z;
    endfunction

    state_e       state_q, state_d;
    logic [127:0] s_q, s_d;
    logic [64:0]  cnt_q, cnt_d;
    logic [64:0]  total_q, total_d;
    logic [127:0] size_q, size_d;
    logic [127:0] h_q, h_d;
    logic [127:0] ej0_q, ej0_d;
    logic [127:0] exp_q, exp_d;
    logic [127:0] tag_q, tag_d;
    logic         ok_q, ok_d;
    logic         done_q, done_d;

    logic [64:0]  total_w;
    logic [127:0] mul_a;
    logic [127:0] mul_p;
    logic [127:0] tag_calc;

    assign total_w = ({1'b0, i_instance_size[127:64]} + {1'b0, i_instance_size[63:0]}) >> 7;

    // Single shared multiplier: data blocks in ABSORB, length block in LEN.
    assign mul_a    = (state_q == StLen) ? (s_q ^ size_q) : (s_q ^ i_block);
    assign mul_p    = fn_product(mul_a, h_q);
    assign tag_calc = mul_p ^ ej0_q;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        total_d = total_q;
        size_d  = size_q;
        h_d     = h_q;
        ej0_d   = ej0_q;
        exp_d   = exp_q;
        tag_d   = tag_q;
        ok_d    = ok_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    size_d  = i_instance_size;
                    h_d     = i_h;
                    ej0_d   = i_encrypted_j0;
                    exp_d   = i_expected_tag;
                    total_d = total_w;
                    s_d     = '0;
                    cnt_d   = '0;
                    state_d = (total_w != '0) ? StAbsorb : StLen;
                end
            end
            StAbsorb: begin
                if (i_valid) begin
                    s_d   = mul_p;
                    cnt_d = cnt_q + 65'd1;
                    if (cnt_q == total_q - 65'd1) begin
                        state_d = StLen;
                    end
                end
            end
            StLen: begin
                tag_d   = tag_calc;
                ok_d    = (tag_calc[127 -: TAG_BITS] == exp_q[127 -: TAG_BITS]);
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q <= StIdle;
            s_q     <= '0;
            cnt_q   <= '0;
            total_q <= '0;
            size_q  <= '0;
            h_q     <= '0;
            ej0_q   <= '0;
            exp_q   <= '0;
            tag_q   <= '0;
            ok_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
            size_q  <= size_d;
            h_q     <= h_d;
            ej0_q   <= ej0_d;
            exp_q   <= exp_d;
            tag_q   <= tag_d;
            ok_q    <= ok_d;
            done_q  <= done_d;
        end
    end

    assign o_ready  = (state_q == StAbsorb);
    assign o_busy   = (state_q != StIdle);
    assign o_done   = done_q;
    assign o_tag    = tag_q;
    assign o_tag_ok = ok_q;

endmodule

// File: tb/tb_aes_gcm_tag_verify.sv
// Directed bench for aes_gcm_tag_verify using NIST GCM test cases 1 and 2,
// with a 96-bit-tag build alongside the full-width one.
module tb_aes_gcm_tag_verify;

    localparam logic [127:0] H_TC    = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] EJ0_TC  = 128'h58e2fccefa7e3061367f1d57a4e7455a;
    localparam logic [127:0] C_TC2   = 128'h0388dace60b6a392f328c2b971b2fe78;
    localparam logic [127:0] TAG_TC2 = 128'hab6e47d42cec13bdf53a67b21257bddf;
    localparam logic [127:0] SZ_TC2  = {64'd0, 64'd128};
    localparam logic [127:0] JUNK    = 128'hdeadbeef_01234567_89abcdef_cafef00d;

    logic         clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_start = 1'b0;
    logic [127:0] i_instance_size = '0;
    logic [127:0] i_h = '0;
    logic [127:0] i_encrypted_j0 = '0;
    logic [127:0] i_expected_tag = '0;
    logic         i_valid = 1'b0;
    logic [127:0] i_block = '0;

    logic         o_ready, o_busy, o_done, o_tag_ok;
    logic [127:0] o_tag;
    logic         r96, b96, d96, ok96;
    logic [127:0] t96;

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;

    aes_gcm_tag_verify #(.TAG_BITS(128)) dut (
        .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_instance_size(i_instance_size),
        .i_h(i_h), .i_encrypted_j0(i_encrypted_j0), .i_expected_tag(i_expected_tag),
        .i_valid(i_valid), .i_block(i_block), .o_ready(o_ready), .o_busy(o_busy),
        .o_done(o_done), .o_tag(o_tag), .o_tag_ok(o_tag_ok)
    );

    aes_gcm_tag_verify #(.TAG_BITS(96)) dut96 (
        .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_instance_size(i_instance_size),
        .i_h(i_h), .i_encrypted_j0(i_encrypted_j0), .i_expected_tag(i_expected_tag),
        .i_valid(i_valid), .i_block(i_block), .o_ready(r96), .o_busy(b96),
        .o_done(d96), .o_tag(t96), .o_tag_ok(ok96)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string        name;
        logic [127:0] size;
        logic [127:0] ej0;
        logic [127:0] exp_in;
        int           nblk;
        int           gaps;
        logic [127:0] tag;
        logic         ok;
        logic         ok96;
    } vec_t;

    vec_t vecs[6];

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, act, req);
        end
    endtask

    task automatic check128(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    // Waits up to a bounded number of cycles for o_done, returning edges since t0.
    task automatic wait_done(input string name, input int unsigned t0, output int lat);
        for (int k = 0; k < 20 && !o_done; k++) @(negedge clk);
        check1({name, "_done_seen"}, o_done, 1'b1);
        lat = int'(cyc - t0);
    endtask

    task automatic run_vec(input vec_t v);
        int unsigned t0;
        int          lat;
        @(negedge clk);
        i_start         = 1'b1;
        i_instance_size = v.size;
        i_h             = H_TC;
        i_encrypted_j0  = v.ej0;
        i_expected_tag  = v.exp_in;
        @(negedge clk);
        t0 = cyc;
        i_start         = 1'b0;
        // Scramble configuration inputs: only the start-cycle values may matter.
        i_instance_size = JUNK;
        i_h             = ~JUNK;
        i_encrypted_j0  = JUNK;
        i_expected_tag  = ~JUNK;
        check1({v.name, "_busy"}, o_busy, 1'b1);
        check1({v.name, "_ready"}, o_ready, (v.nblk > 0));
        if (v.nblk > 0) begin
            for (int g = 0; g < v.gaps; g++) begin
                i_start = (g == 0);
                @(negedge clk);
            end
            i_start = 1'b0;
            i_valid = 1'b1;
            i_block = C_TC2;
            @(negedge clk);
            i_valid = 1'b0;
            i_block = JUNK;
        end
        wait_done(v.name, t0, lat);
        check_int({v.name, "_latency"}, lat, v.nblk + v.gaps + 1);
        check128({v.name, "_tag"}, o_tag, v.tag);
        check1({v.name, "_ok"}, o_tag_ok, v.ok);
        check1({v.name, "_ok96"}, ok96, v.ok96);
        check1({v.name, "_idle_on_done"}, o_busy, 1'b0);
        @(negedge clk);
        check1({v.name, "_done_one_cycle"}, o_done, 1'b0);
        check128({v.name, "_tag_held"}, o_tag, v.tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t0;
        int          lat;

        vecs[0] = '{"tc1", '0, EJ0_TC, EJ0_TC, 0, 0, EJ0_TC, 1'b1, 1'b1};
        vecs[1] = '{"tc2", SZ_TC2, EJ0_TC, TAG_TC2, 1, 0, TAG_TC2, 1'b1, 1'b1};
        vecs[2] = '{"tc2_lsb_flip", SZ_TC2, EJ0_TC, TAG_TC2 ^ 128'd1, 1, 0, TAG_TC2,
                    1'b0, 1'b1};
        vecs[3] = '{"tc2_msb_flip", SZ_TC2, EJ0_TC, TAG_TC2 ^ {1'b1, 127'd0}, 1, 0, TAG_TC2,
                    1'b0, 1'b0};
        vecs[4] = '{"tc2_gap3", SZ_TC2, EJ0_TC, TAG_TC2, 1, 3, TAG_TC2, 1'b1, 1'b1};
        vecs[5] = '{"tc1_mid_flip", '0, EJ0_TC, EJ0_TC ^ (128'd1 << 40), 0, 0, EJ0_TC,
                    1'b0, 1'b0};

        repeat (2) @(negedge clk);
        check1("rst_ready", o_ready, 1'b0);
        check1("rst_busy", o_busy, 1'b0);
        check1("rst_done", o_done, 1'b0);
        check128("rst_tag", o_tag, '0);
        check1("rst_ok", o_tag_ok, 1'b0);
        i_rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Reset in the middle of a 4-block instance.
        @(negedge clk);
        i_start         = 1'b1;
        i_instance_size = {64'd0, 64'd512};
        i_h             = 128'hb83b533708bf535d0aa6e52980d53b78;
        i_encrypted_j0  = JUNK;
        i_expected_tag  = JUNK;
        @(negedge clk);
        i_start = 1'b0;
        i_valid = 1'b1;
        i_block = 128'h42831ec2217774244b7221b784d0d49c;
        @(negedge clk);
        i_block = 128'he3aa212f2c02a4e035c17e2329aca12e;
        @(negedge clk);
        i_rst   = 1'b1;
        i_block = 128'h21d514b25466931c7d8f6a5aac84aa05;
        @(negedge clk);
        check1("midrst_ready", o_ready, 1'b0);
        check1("midrst_busy", o_busy, 1'b0);
        check1("midrst_done", o_done, 1'b0);
        check128("midrst_tag", o_tag, '0);
        i_rst   = 1'b0;
        i_valid = 1'b1;
        i_block = 128'h1ba30b396a0aac973d58e091473f5985;
        begin
            logic any_done;
            any_done = 1'b0;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                any_done = any_done | o_done | o_busy;
            end
            check1("midrst_stays_idle", any_done, 1'b0);
        end
        i_valid = 1'b0;
        run_vec(vecs[1]);

        // Back-to-back: TC2, then TC1 started in the o_done cycle.
        @(negedge clk);
        i_start         = 1'b1;
        i_instance_size = SZ_TC2;
        i_h             = H_TC;
        i_encrypted_j0  = EJ0_TC;
        i_expected_tag  = TAG_TC2;
        @(negedge clk);
        t0      = cyc;
        i_start = 1'b0;
        i_valid = 1'b1;
        i_block = C_TC2;
        @(negedge clk);
        i_valid = 1'b0;
        wait_done("b2b_tc2", t0, lat);
        check_int("b2b_tc2_latency", lat, 2);
        check128("b2b_tc2_tag", o_tag, TAG_TC2);
        check1("b2b_tc2_ok", o_tag_ok, 1'b1);
        i_start         = 1'b1;
        i_instance_size = '0;
        i_expected_tag  = EJ0_TC;
        @(negedge clk);
        t0      = cyc;
        i_start = 1'b0;
        check1("b2b_tc1_accepted", o_busy, 1'b1);
        wait_done("b2b_tc1", t0, lat);
        check_int("b2b_tc1_latency", lat, 1);
        check128("b2b_tc1_tag", o_tag, EJ0_TC);
        check1("b2b_tc1_ok", o_tag_ok, 1'b1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
